// File: rtl/cam_match_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : cam_match_scanner_if
// Purpose  : Bundles every non-clock signal of cam_match_scanner into one
//            interface: request channel, CAM lookup channel, address stream
//            and the per-request summary.
// Modports : slave  - the scanner itself
//            master - the environment (requester, CAM, stream consumer)
// Signals  : req_valid/req_key/req_ready      request handshake
//            lookup_key/match_vec             CAM key out, match bits in
//            out_valid/out_addr/out_last/out_ready  matching-address stream
//            done/hit/min_addr/max_addr/hit_count   per-request summary
// Revision : 1.0 - initial release
// ============================================================================
interface cam_match_scanner_if #(
    parameter int ENTRIES = 8,
    parameter int AW      = 3,
    parameter int DW      = 4,
    parameter int CW      = 4
);
    logic               req_valid;
    logic [DW-1:0]      req_key;
    logic               req_ready;
    logic [DW-1:0]      lookup_key;
    logic [ENTRIES-1:0] match_vec;
    logic               out_valid;
    logic [AW-1:0]      out_addr;
    logic               out_last;
    logic               out_ready;
    logic               done;
    logic               hit;
    logic [AW-1:0]      min_addr;
    logic [AW-1:0]      max_addr;
    logic [CW-1:0]      hit_count;

    modport slave (
        input  req_valid, req_key, match_vec, out_ready,
        output req_ready, lookup_key, out_valid, out_addr, out_last,
               done, hit, min_addr, max_addr, hit_count
    );

    modport master (
        output req_valid, req_key, match_vec, out_ready,
        input  req_ready, lookup_key, out_valid, out_addr, out_last,
               done, hit, min_addr, max_addr, hit_count
    );
endinterface
`default_nettype wire

// File: rtl/cam_match_scanner.sv
`default_nettype none
// ============================================================================
// Module   : cam_match_scanner
// Purpose  : Accepts a lookup key, drives it to the CAM, snapshots the CAM
//            match vector one cycle later, then streams every matching entry
//            address (lowest first) and closes with a one-cycle done pulse
//            carrying hit / min / max / count.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - cam_match_scanner_if.slave (all handshake/data signals)
// Revision : 1.0 - initial release
// ============================================================================
module cam_match_scanner #(
    parameter int ENTRIES = 8,
    parameter int AW      = 3,
    parameter int DW      = 4,
    parameter int CW      = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cam_match_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      key_q, key_d;
    logic [ENTRIES-1:0] vec_q, vec_d;
    logic               hit_q, hit_d;
    logic [AW-1:0]      min_q, min_d;
    logic [AW-1:0]      max_q, max_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Clears to 0 in reset and sets on the first clock afterwards, so that
    // req_ready stays low throughout reset and rises in the first IDLE cycle.
    logic               init_q;

    logic [AW-1:0]      mv_lo, mv_hi, vq_lo;
    logic [CW-1:0]      mv_cnt;
    logic               vq_last;
    logic               req_ready_w;

    // Priority encoders and popcount on the live CAM match vector.
    always_comb begin
        mv_lo  = '0;
        mv_hi  = '0;
        mv_cnt = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (bus.match_vec[i]) mv_lo = AW'(i);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (bus.match_vec[i]) mv_hi = AW'(i);
            mv_cnt = mv_cnt + CW'(bus.match_vec[i]);
        end
    end

    // Lowest remaining address of the snapshot; last when at most one bit
    // remains (SCAN is only entered with a non-zero snapshot).
    always_comb begin
        vq_lo = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vec_q[i]) vq_lo = AW'(i);
        end
        vq_last = ((vec_q & (vec_q - ENTRIES'(1))) == '0);
    end

    assign req_ready_w = init_q && (state_q == S_IDLE);

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        vec_d         = vec_q;
        hit_d         = hit_q;
        min_d         = min_q;
        max_d         = max_q;
        cnt_d         = cnt_q;
        bus.out_valid = 1'b0;
        bus.out_addr  = '0;
        bus.out_last  = 1'b0;
        bus.done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_w) begin
                    key_d   = bus.req_key;
                    state_d = S_PROBE;
                end
            end
            S_PROBE: begin
                vec_d   = bus.match_vec;
                hit_d   = |bus.match_vec;
                min_d   = mv_lo;
                max_d   = mv_hi;
                cnt_d   = mv_cnt;
                state_d = (bus.match_vec == '0) ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
                bus.out_valid = 1'b1;
                bus.out_addr  = vq_lo;
                bus.out_last  = vq_last;
                if (bus.out_ready) begin
                    vec_d = vec_q & ~(ENTRIES'(1) << vq_lo);
                    if (vq_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            vec_q   <= '0;
            hit_q   <= 1'b0;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            vec_q   <= vec_d;
            hit_q   <= hit_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
        end
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.lookup_key = key_q;
    assign bus.hit        = hit_q;
    assign bus.min_addr   = min_q;
    assign bus.max_addr   = max_q;
    assign bus.hit_count  = cnt_q;

endmodule
`default_nettype wire

// File: doc/cam_match_scanner.md
Name: cam_match_scanner

Overview:
- Downstream consumer of the 8-entry, 4-bit CAM file.
- Accepts lookup requests over a valid/ready handshake and drives the lookup key to the CAM.
- Snapshots the CAM's per-entry match vector, then streams every matching entry address, lowest index first, one per handshake.
- Finishes each request with a one-cycle summary: hit flag, min/max matching address and hit count. This replaces ad-hoc priority encoding after the CAM.

Parameters:
ENTRIES, 8, number of CAM entries (width of match vector)
AW, 3, address width, equals clog2(ENTRIES)
DW, 4, key/data width
CW, 4, hit-count width, equals clog2(ENTRIES+1)

Ports:
clk  in  1  single clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  lookup request present
req_key  in  DW  key to search for
req_ready  out  1  scanner can accept a request
lookup_key  out  DW  key driven to CAM lookup input (registered)
match_vec  in  ENTRIES  per-entry match bits from CAM comparators (bit i = entry i)
out_valid  out  1  out_addr holds a matching address
out_addr  out  AW  matching entry index
out_last  out  1  current out_addr is the final match of this request
out_ready  in  1  consumer accepts out_addr
done  out  1  one-cycle pulse: request complete
hit  out  1  at least one entry matched (valid with done, held after)
min_addr  out  AW  lowest matching index (0 on miss)
max_addr  out  AW  highest matching index (0 on miss)
hit_count  out  CW  number of matching entries

Behaviour:
- Reset (reset low, any time, asynchronous):
  - state=IDLE; key_r, vec_r, hit, min_addr, max_addr, hit_count all clear to 0; done=0, out_valid=0.
  - req_ready is forced to 0 while reset is low and goes to 1 in the first IDLE cycle after release.
- lookup_key = key_r at all times. The CAM matches combinationally, so match_vec is valid one cycle after key_r updates.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: key_r<=req_key, go to PROBE.
- PROBE (exactly 1 cycle):
  - req_ready=0, out_valid=0.
  - vec_r<=match_vec.
  - Registers computed from match_vec: hit=|match_vec; min_addr=lowest set index; max_addr=highest set index; hit_count=popcount, range 0..ENTRIES.
  - If match_vec==0 go to DONE, else go to SCAN.
- SCAN:
  - out_valid=1; out_addr=lowest set index of vec_r; out_last=1 iff exactly one bit of vec_r is set.
  - On out_ready: clear that bit of vec_r. If out_last go to DONE, else stay in SCAN; the next address appears the following cycle.
  - out_ready low stalls; out_addr and out_last stay stable.
- DONE (exactly 1 cycle):
  - done=1, out_valid=0, req_ready=0, then go to IDLE.
  - hit/min_addr/max_addr/hit_count hold until the next PROBE overwrites them.
- Latency:
  - Request accepted at cycle N, PROBE at N+1.
  - Hit: first out_valid at N+2.
  - Miss: done at N+2.
  - With out_ready held high, k matches give done at N+2+k.
  - Back-to-back requests: next accept no earlier than the cycle after done.
- Snapshot rule: match_vec changes after PROBE are ignored for the current request, including a CAM rewrite mid-scan. Streamed addresses reflect the CAM contents at PROBE.
- req_key changes while not accepted are ignored. req_valid in any state other than IDLE is not accepted.
- Reset mid-request aborts immediately: no further out_valid and no done pulse.
- All entries matching gives hit_count=ENTRIES (1000b for 8). CW must hold this without wrap.
- X-free: out_addr=0 whenever out_valid=0.

Test Plan:
- After reset release, req_key=4'b1010 with CAM at init values (entry i = 8+i) -> match_vec=00000100, out_addr=2 with out_last=1 at cycle N+2, done at N+3, hit=1, min=max=2, hit_count=1.
- Request key 4'b0011 against the init CAM -> no out_valid; done at N+2 with hit=0, min_addr=0, max_addr=0, hit_count=0.
- Entries 1, 4, 6 hold 4'h5, request 4'h5, out_ready=1 -> out_addr sequence 1,4,6 on consecutive cycles, out_last only with 6, min=1, max=6, hit_count=3.
- All entries hold 4'hF, out_ready toggles 1/0 -> 8 addresses 0..7 in order, each held stable while out_ready=0, hit_count=8, max_addr=7.
- Same setup as the three-match case, rewrite entry 4 to 4'h0 during SCAN -> stream still 1,4,6 (snapshot). Separately, assert reset low mid-SCAN -> out_valid=0 immediately, no done; req_ready=1 one cycle after release.
